mem_port_arbiter: RTL

- Shares the single-port unified memory between instruction fetch and the data memory stage of the 5-stage pipeline.
- Accepts one request at a time from either side, drives one memory transaction, and routes the response back to its owner.
- Data side has priority; a starvation counter guarantees fetch progress.
- Exports fetch and data stall indications for the hazard logic.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_starve_prio.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } arb_owner_t;

   localparam int STARVE_WIDTH = 4;
   localparam logic [STARVE_WIDTH-1:0] STARVE_SAT = 4'd15;

endpackage

// File: rtl/mem_port_arbiter_starve_prio.sv
// Data-first priority decision with a saturating counter of contested fetch losses.
module arb_starve_prio
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_STARVE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic d_req,
   input  logic decide_en,
   output logic grant_fetch,
   output logic grant_data
);

   logic [STARVE_WIDTH-1:0] starve_cnt_reg;
   logic [STARVE_WIDTH-1:0] starve_cnt_next;
   logic                    fetch_wins;

   always_comb begin
      fetch_wins  = if_req & (~d_req | (starve_cnt_reg == STARVE_WIDTH'(MAX_STARVE)));
      grant_fetch = decide_en & fetch_wins;
      grant_data  = decide_en & d_req & ~fetch_wins;
   end

   // Only a data win while fetch was also asking counts as starvation.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (grant_fetch) begin
         starve_cnt_next = '0;
      end else if (grant_data && if_req && (starve_cnt_reg != STARVE_SAT)) begin
         starve_cnt_next = starve_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage; one transaction in flight.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MAX_STARVE    = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_req,
   input  logic [ADDRESS_WIDTH-1:0] if_addr,
   output logic                     if_gnt,
   output logic                     if_rvalid,
   output logic [DATA_WIDTH-1:0]    if_rdata,
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [ADDRESS_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0]    d_wdata,
   output logic                     d_gnt,
   output logic                     d_rvalid,
   output logic [DATA_WIDTH-1:0]    d_rdata,
   output logic                     mem_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic                     mem_ready,
   input  logic                     mem_rvalid,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic                     stall_f,
   output logic                     stall_m,
   output logic                     busy,
   output logic                     err
);

   arb_state_t               state_reg;
   arb_owner_t               owner_reg;
   logic                     mem_req_reg;
   logic                     mem_we_reg;
   logic [ADDRESS_WIDTH-1:0] mem_addr_reg;
   logic [DATA_WIDTH-1:0]    mem_wdata_reg;
   logic                     err_reg;
   logic                     decide_en;
   logic                     grant_fetch;
   logic                     grant_data;
   logic                     route;

   assign decide_en = rst & (state_reg == ARB_IDLE);

   arb_starve_prio #(
      .MAX_STARVE (MAX_STARVE)
   ) u_prio (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .d_req       (d_req),
      .decide_en   (decide_en),
      .grant_fetch (grant_fetch),
      .grant_data  (grant_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ARB_IDLE;
         owner_reg     <= OWN_NONE;
         mem_req_reg   <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         case (state_reg)
            ARB_IDLE: begin
               if (mem_rvalid) begin
                  err_reg <= 1'b1;
               end
               if (grant_fetch) begin
                  mem_req_reg  <= 1'b1;
                  mem_we_reg   <= 1'b0;
                  mem_addr_reg <= if_addr;
                  owner_reg    <= OWN_FETCH;
                  state_reg    <= ARB_ISSUE;
               end else if (grant_data) begin
                  mem_req_reg   <= 1'b1;
                  mem_we_reg    <= d_we;
                  mem_addr_reg  <= d_addr;
                  mem_wdata_reg <= d_wdata;
                  owner_reg     <= OWN_DATA;
                  state_reg     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               // A response before the request is even accepted cannot be ours.
               if (mem_rvalid) begin
                  err_reg <= 1'b1;
               end
               if (mem_ready) begin
                  mem_req_reg <= 1'b0;
                  state_reg   <= ARB_WAIT;
               end
            end
            ARB_WAIT: begin
               if (mem_rvalid) begin
                  owner_reg <= OWN_NONE;
                  state_reg <= ARB_IDLE;
               end
            end
            default: begin
               owner_reg   <= OWN_NONE;
               mem_req_reg <= 1'b0;
               state_reg   <= ARB_IDLE;
            end
         endcase
      end
   end

   assign route     = rst & (state_reg == ARB_WAIT) & mem_rvalid;
   assign if_gnt    = grant_fetch;
   assign d_gnt     = grant_data;
   assign if_rvalid = route & (owner_reg == OWN_FETCH);
   assign d_rvalid  = route & (owner_reg == OWN_DATA);
   assign if_rdata  = {DATA_WIDTH{rst}} & mem_rdata;
   assign d_rdata   = {DATA_WIDTH{rst}} & mem_rdata;

   // Registered outputs are forced low while reset is held, before the edge clears them.
   assign mem_req   = rst & mem_req_reg;
   assign mem_we    = rst & mem_we_reg;
   assign mem_addr  = {ADDRESS_WIDTH{rst}} & mem_addr_reg;
   assign mem_wdata = {DATA_WIDTH{rst}} & mem_wdata_reg;
   assign busy      = rst & (state_reg != ARB_IDLE);
   assign err       = rst & err_reg;

   assign stall_f = if_req & ~if_rvalid;
   assign stall_m = d_req | ((owner_reg == OWN_DATA) & (state_reg != ARB_IDLE) & ~d_rvalid);

endmodule
